// File: rtl/rpn_pkg.sv
// Shared constants and FSM state encoding for the RPN ALU arbiter.
package rpn_pkg;

    localparam logic [7:0] EQU = 8'h3d;   // '=' ends an expression
    localparam logic [7:0] ERR = 8'h3f;   // '?' returned on an aborted expression

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        GAP      = 3'd2,
        HOLD     = 3'd3,
        WAIT_RES = 3'd4,
        DELIVER  = 3'd5,
        ABORT    = 3'd6
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    logic [PW-1:0] cand;

    // Walk the requesters starting at ptr; the first one found wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(ptr) + k >= N_REQ) begin
                cand = PW'(int'(ptr) + k - N_REQ);
            end else begin
                cand = PW'(int'(ptr) + k);
            end
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rpn_alu_arbiter.sv
// Shares one RPN ALU between N_REQ character sources at expression granularity.
// A winner owns the ALU from its first char until its '=' result is delivered;
// chars are paced so the ALU gets MIN_GAP idle cycles after each accept.
// Optional: define RPN_ARB_TIMEOUT_EN to abort an expression whose owner stalls
// TIMEOUT_CYC cycles in HOLD (injects '=', returns '?').
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no owner; round-robin pick among requesters
// SEND     | ALU_IN_STB high with owner char, waiting ALU_IN_ACK
// GAP      | pacing delay of MIN_GAP cycles after an accepted char
// HOLD     | owner has no char ready; grant kept, others ignored
// WAIT_RES | '=' sent, waiting ALU result
// DELIVER  | result presented to owner, waiting its REQ_OUT_ACK
// ABORT    | owner stalled too long; inject '=' (timeout build only)
module rpn_alu_arbiter #(
    parameter int N_REQ   = 2,
    parameter int MIN_GAP = 3
`ifdef RPN_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     REQ_IN_STB,
    input  logic [8*N_REQ-1:0]   REQ_IN_CHAR,
    output logic [N_REQ-1:0]     REQ_IN_ACK,
    output logic [N_REQ-1:0]     REQ_OUT_STB,
    output logic [7:0]           REQ_OUT_CHAR,
    input  logic [N_REQ-1:0]     REQ_OUT_ACK,
    output logic [N_REQ-1:0]     GRANT,
    output logic                 ALU_IN_STB,
    output logic [7:0]           ALU_IN_CHAR,
    input  logic                 ALU_IN_ACK,
    input  logic                 ALU_OUT_STB,
    input  logic [7:0]           ALU_OUT_CHAR,
    output logic                 ALU_OUT_ACK
);

    import rpn_pkg::*;

    localparam int PW = $clog2(N_REQ);
    localparam int GW = $clog2(MIN_GAP);
`ifdef RPN_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
`endif

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    ptr_q, ptr_d;        // highest-priority index for the next pick
    logic [7:0]       char_q, char_d;
    logic [7:0]       res_q, res_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0] in_ack_q, in_ack_d;
    logic             out_ack_q, out_ack_d;
    logic             abort_q, abort_d;    // current '=' was injected, not from the owner
`ifdef RPN_ARB_TIMEOUT_EN
    logic [TW-1:0]    to_q, to_d;
`endif

    logic [7:0]       req_char [N_REQ];
    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic             owner_stb;

    for (genvar g = 0; g < N_REQ; g++) begin : g_char
        assign req_char[g] = REQ_IN_CHAR[8*g +: 8];
    end

    rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
        .req    (REQ_IN_STB),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign owner_stb = REQ_IN_STB[owner_q];

    // Next-state and next-register values
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        char_d    = char_q;
        res_d     = res_q;
        gap_d     = gap_q;
        in_ack_d  = '0;
        out_ack_d = 1'b0;
        abort_d   = abort_q;
`ifdef RPN_ARB_TIMEOUT_EN
        to_d      = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    char_d  = req_char[pick_idx];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ALU_IN_ACK) begin
                    if (!abort_q) begin
                        in_ack_d = grant_q;
                    end
                    if (char_q == EQU) begin
                        state_d = WAIT_RES;
                    end else begin
                        gap_d   = GW'(MIN_GAP - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (owner_stb) begin
                        char_d  = req_char[owner_q];
                        state_d = SEND;
                    end else begin
`ifdef RPN_ARB_TIMEOUT_EN
                        to_d    = TW'(TIMEOUT_CYC - 1);
`endif
                        state_d = HOLD;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            HOLD: begin
                if (owner_stb) begin
                    char_d  = req_char[owner_q];
                    state_d = SEND;
                end
`ifdef RPN_ARB_TIMEOUT_EN
                else if (to_q == '0) begin
                    state_d = ABORT;
                end else begin
                    to_d = to_q - 1'b1;
                end
`endif
            end
`ifdef RPN_ARB_TIMEOUT_EN
            ABORT: begin
                char_d  = EQU;
                abort_d = 1'b1;
                state_d = SEND;
            end
`endif
            WAIT_RES: begin
                if (ALU_OUT_STB) begin
                    res_d     = abort_q ? ERR : ALU_OUT_CHAR;
                    out_ack_d = 1'b1;
                    state_d   = DELIVER;
                end
            end
            DELIVER: begin
                if (|(REQ_OUT_ACK & grant_q)) begin
                    grant_d = '0;
                    abort_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            char_q    <= '0;
            res_q     <= '0;
            gap_q     <= '0;
            in_ack_q  <= '0;
            out_ack_q <= 1'b0;
            abort_q   <= 1'b0;
`ifdef RPN_ARB_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            char_q    <= char_d;
            res_q     <= res_d;
            gap_q     <= gap_d;
            in_ack_q  <= in_ack_d;
            out_ack_q <= out_ack_d;
            abort_q   <= abort_d;
`ifdef RPN_ARB_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    assign GRANT        = grant_q;
    assign ALU_IN_STB   = (state_q == SEND);
    assign ALU_IN_CHAR  = char_q;
    assign ALU_OUT_ACK  = out_ack_q;
    assign REQ_IN_ACK   = in_ack_q;
    assign REQ_OUT_STB  = (state_q == DELIVER) ? grant_q : '0;
    assign REQ_OUT_CHAR = res_q;

endmodule

// File: tb/tb_rpn_alu_arbiter.sv
// Self-checking bench for rpn_alu_arbiter with a behavioural stack ALU.
module tb_rpn_alu_arbiter;

    localparam int N_REQ   = 2;
    localparam int MIN_GAP = 3;
    localparam int TO_CYC  = 64;
    localparam int K_RAND  = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stb0 = 1'b0, stb1 = 1'b0, oack0 = 1'b0, oack1 = 1'b0;
    logic [7:0]  ch0 = 8'h00, ch1 = 8'h00;
    logic [1:0]  REQ_IN_ACK, REQ_OUT_STB, GRANT;
    logic [7:0]  REQ_OUT_CHAR, ALU_IN_CHAR;
    logic        ALU_IN_STB, ALU_OUT_ACK;
    logic        alu_in_ack, alu_out_stb;
    logic [7:0]  alu_out_char;
    logic [2:0]  alu_cnt;

    int tests_run = 0;
    int failures  = 0;
    int cyc = 0;

    logic [7:0] alu_log[$];
    int stk[$];
    int sa, sb, sr, stop;

    int min_gap = 1000, gap_run = 0, ack_bad = 0, grant_bad = 0;
    bit armed = 1'b0;

    int lat0, ack0, done0, lat1, ack1, done1, m;
    string e0[K_RAND], e1[K_RAND];
    logic [7:0] r0[K_RAND], r1[K_RAND];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    rpn_alu_arbiter #(
        .N_REQ(N_REQ), .MIN_GAP(MIN_GAP)
`ifdef RPN_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_IN_STB({stb1, stb0}), .REQ_IN_CHAR({ch1, ch0}), .REQ_IN_ACK(REQ_IN_ACK),
        .REQ_OUT_STB(REQ_OUT_STB), .REQ_OUT_CHAR(REQ_OUT_CHAR), .REQ_OUT_ACK({oack1, oack0}),
        .GRANT(GRANT),
        .ALU_IN_STB(ALU_IN_STB), .ALU_IN_CHAR(ALU_IN_CHAR), .ALU_IN_ACK(alu_in_ack),
        .ALU_OUT_STB(alu_out_stb), .ALU_OUT_CHAR(alu_out_char), .ALU_OUT_ACK(ALU_OUT_ACK)
    );

    // Stack-machine ALU: registered accept, result some cycles after '='
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_in_ack   <= 1'b0;
            alu_out_stb  <= 1'b0;
            alu_out_char <= 8'h00;
            alu_cnt      <= 3'd0;
            stk.delete();
        end else begin
            alu_in_ack <= ALU_IN_STB && !alu_in_ack;
            if (ALU_IN_STB && !alu_in_ack) begin
                alu_log.push_back(ALU_IN_CHAR);
                if (ALU_IN_CHAR >= 8'h30 && ALU_IN_CHAR <= 8'h39) begin
                    stk.push_back(int'(ALU_IN_CHAR) - 48);
                end else if (ALU_IN_CHAR == 8'h3d) begin
                    stop = (stk.size() > 0) ? stk[$] : 0;
                    stk.delete();
                    alu_out_char <= 8'(48 + (stop % 10));
                    alu_cnt      <= 3'(1 + $urandom_range(3));
                end else if (stk.size() >= 2) begin
                    sb = stk.pop_back();
                    sa = stk.pop_back();
                    case (ALU_IN_CHAR)
                        8'h2b:   sr = sa + sb;
                        8'h2d:   sr = sa - sb;
                        8'h2a:   sr = sa * sb;
                        default: sr = 0;
                    endcase
                    stk.push_back(sr);
                end
            end
            if (alu_cnt != 3'd0) begin
                alu_cnt <= alu_cnt - 3'd1;
                if (alu_cnt == 3'd1) alu_out_stb <= 1'b1;
            end else if (ALU_OUT_ACK) begin
                alu_out_stb <= 1'b0;
            end
        end
    end

    // Observers: pacing gap after each ALU accept, ack/grant sanity
    always @(negedge CLK) begin
        if (RST) begin
            armed = 1'b0;
        end else begin
            if (alu_in_ack) begin
                armed = 1'b1;
                gap_run = 0;
            end else if (armed) begin
                if (ALU_IN_STB) begin
                    if (gap_run < min_gap) min_gap = gap_run;
                    armed = 1'b0;
                end else begin
                    gap_run++;
                end
            end
            if ((REQ_IN_ACK & ~GRANT) != 2'b00) ack_bad++;
            if (GRANT == 2'b11) grant_bad++;
        end
    end

    task automatic set_req(input int idx, input logic v, input logic [7:0] c);
        if (idx == 0) begin stb0 = v; ch0 = c; end
        else          begin stb1 = v; ch1 = c; end
    endtask

    task automatic set_oack(input int idx, input logic v);
        if (idx == 0) oack0 = v;
        else          oack1 = v;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_req(0, 1'b0, 8'h00);
        set_req(1, 1'b0, 8'h00);
        oack0 = 1'b0;
        oack1 = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        alu_log.delete();
    endtask

    function automatic int log_mismatch(input string exp_s);
        if (alu_log.size() != exp_s.len()) return -2;
        for (int i = 0; i < exp_s.len(); i++) begin
            if (alu_log[i] != exp_s[i]) return i;
        end
        return -1;
    endfunction

    // Requester behaviour: one expression, then wait, check and ack its result
    task automatic drive_expr(input int idx, input string s, input logic [7:0] exp_res,
                              input int max_idle, output int lat, output int first_ack,
                              output int done);
        bit got;
        lat = -1; first_ack = -1; done = -1;
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) repeat ($urandom_range(max_idle)) @(negedge CLK);
            set_req(idx, 1'b1, s[i]);
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge CLK);
                if (i == 0 && lat < 0 && ALU_IN_STB && GRANT[idx]) lat = t + 1;
                if (REQ_IN_ACK[idx]) begin
                    got = 1'b1;
                    if (i == 0) first_ack = cyc;
                end
            end
            set_req(idx, 1'b0, 8'h00);
            if (!got) begin
                tests_run++; failures++;
                $display("FAIL ack_timeout r%0d char %0d: no REQ_IN_ACK, required one within 400 cycles", idx, i);
                return;
            end
        end
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge CLK);
            if (REQ_OUT_STB[idx]) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            failures++;
            $display("FAIL result_timeout r%0d: REQ_OUT_STB never set, required within 400 cycles", idx);
            return;
        end
        if (REQ_OUT_CHAR !== exp_res) begin
            failures++;
            $display("FAIL result r%0d \"%s\": got %02h, required %02h", idx, s, REQ_OUT_CHAR, exp_res);
        end
        set_oack(idx, 1'b1);
        @(negedge CLK);
        set_oack(idx, 1'b0);
        done = cyc;
    endtask

    task automatic gen_expr(output string s, output logic [7:0] r);
        int a, b, op, v;
        do begin
            a = $urandom_range(9); b = $urandom_range(9); op = $urandom_range(2);
            v = (op == 0) ? a + b : (op == 1) ? a - b : a * b;
        end while (v < 0 || v > 9);
        s = "00+=";
        s.putc(0, 8'(48 + a));
        s.putc(1, 8'(48 + b));
        s.putc(2, (op == 0) ? 8'h2b : (op == 1) ? 8'h2d : 8'h2a);
        r = 8'(48 + v);
    endtask

    task test_reset();
        do_reset();
        tests_run += 7;
        if (GRANT !== 2'b00)       begin failures++; $display("FAIL rst_grant: got %b, required 00", GRANT); end
        if (ALU_IN_STB !== 1'b0)   begin failures++; $display("FAIL rst_alu_in_stb: got %b, required 0", ALU_IN_STB); end
        if (ALU_IN_CHAR !== 8'h00) begin failures++; $display("FAIL rst_alu_in_char: got %02h, required 00", ALU_IN_CHAR); end
        if (ALU_OUT_ACK !== 1'b0)  begin failures++; $display("FAIL rst_alu_out_ack: got %b, required 0", ALU_OUT_ACK); end
        if (REQ_IN_ACK !== 2'b00)  begin failures++; $display("FAIL rst_req_in_ack: got %b, required 00", REQ_IN_ACK); end
        if (REQ_OUT_STB !== 2'b00) begin failures++; $display("FAIL rst_req_out_stb: got %b, required 00", REQ_OUT_STB); end
        if (REQ_OUT_CHAR !== 8'h00) begin failures++; $display("FAIL rst_req_out_char: got %02h, required 00", REQ_OUT_CHAR); end
    endtask

    task test_single();
        drive_expr(0, "34+=", 8'h37, 0, lat0, ack0, done0);
        tests_run += 2;
        if (lat0 != 1) begin failures++; $display("FAIL first_latency: got %0d cycles, required 1", lat0); end
        m = log_mismatch("34+=");
        if (m != -1) begin failures++; $display("FAIL single_stream: diff at %0d, got %0d chars, required 34+=", m, alu_log.size()); end
        @(negedge CLK);
        tests_run++;
        if (GRANT !== 2'b00) begin failures++; $display("FAIL single_release: GRANT %b, required 00", GRANT); end
    endtask

    task test_simultaneous();
        do_reset();
        fork
            drive_expr(0, "34+=", 8'h37, 0, lat0, ack0, done0);
            drive_expr(1, "52-=", 8'h33, 0, lat1, ack1, done1);
        join
        tests_run += 2;
        m = log_mismatch("34+=52-=");
        if (m != -1) begin failures++; $display("FAIL simul_order: diff at %0d, got %0d chars, required 34+=52-=", m, alu_log.size()); end
        if (!(ack1 > done0)) begin failures++; $display("FAIL simul_r1_blocked: r1 first ack cycle %0d, required after r0 done %0d", ack1, done0); end
    endtask

    task test_hold_block();
        do_reset();
        fork
            drive_expr(0, "23*=", 8'h36, 6, lat0, ack0, done0);
            drive_expr(1, "11+=", 8'h32, 0, lat1, ack1, done1);
        join
        tests_run += 2;
        if (!(ack1 > done0)) begin failures++; $display("FAIL hold_r1_blocked: r1 first ack cycle %0d, required after r0 done %0d", ack1, done0); end
        m = log_mismatch("23*=11+=");
        if (m != -1) begin failures++; $display("FAIL hold_stream: diff at %0d, got %0d chars, required 23*=11+=", m, alu_log.size()); end
    endtask

    task test_back_to_back();
        do_reset();
        drive_expr(0, "91-=", 8'h38, 0, lat0, ack0, done0);
        drive_expr(0, "33*=", 8'h39, 0, lat0, ack0, done0);
        tests_run++;
        m = log_mismatch("91-=33*=");
        if (m != -1) begin failures++; $display("FAIL b2b_stream: diff at %0d, got %0d chars, required 91-=33*=", m, alu_log.size()); end
    endtask

    task test_rst_mid();
        bit seen;
        do_reset();
        set_req(0, 1'b1, 8'h37);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge CLK);
            if (ALU_IN_STB) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin failures++; $display("FAIL rst_mid_send: ALU_IN_STB never rose, required within 10 cycles"); end
        RST = 1'b1;
        #1;
        tests_run += 2;
        if (ALU_IN_STB !== 1'b0) begin failures++; $display("FAIL rst_mid_stb: got %b, required 0", ALU_IN_STB); end
        if (GRANT !== 2'b00)     begin failures++; $display("FAIL rst_mid_grant: got %b, required 00", GRANT); end
        set_req(0, 1'b0, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        alu_log.delete();
        drive_expr(1, "81-=", 8'h37, 2, lat1, ack1, done1);
        tests_run++;
        m = log_mismatch("81-=");
        if (m != -1) begin failures++; $display("FAIL rst_mid_after: diff at %0d, got %0d chars, required 81-=", m, alu_log.size()); end
    endtask

    task automatic run_seq(input int idx);
        int l, a, d;
        for (int k = 0; k < K_RAND; k++) begin
            if (idx == 0) drive_expr(0, e0[k], r0[k], 6, l, a, d);
            else          drive_expr(1, e1[k], r1[k], 6, l, a, d);
        end
    endtask

    task test_random();
        string exp_s;
        exp_s = "";
        for (int k = 0; k < K_RAND; k++) begin
            gen_expr(e0[k], r0[k]);
            gen_expr(e1[k], r1[k]);
            exp_s = {exp_s, e0[k], e1[k]};
        end
        do_reset();
        fork
            run_seq(0);
            run_seq(1);
        join
        tests_run++;
        m = log_mismatch(exp_s);
        if (m != -1) begin failures++; $display("FAIL random_rotation: diff at %0d, got %0d chars, required %s", m, alu_log.size(), exp_s); end
    endtask

    task test_spacing_protocol();
        tests_run += 3;
        if (min_gap != MIN_GAP) begin failures++; $display("FAIL min_gap: got %0d idle cycles, required %0d", min_gap, MIN_GAP); end
        if (ack_bad != 0)   begin failures++; $display("FAIL ack_to_non_owner: got %0d events, required 0", ack_bad); end
        if (grant_bad != 0) begin failures++; $display("FAIL grant_onehot: got %0d events, required 0", grant_bad); end
    endtask

`ifdef RPN_ARB_TIMEOUT_EN
    task test_timeout();
        bit got;
        do_reset();
        set_req(0, 1'b1, 8'h35);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge CLK);
            if (REQ_IN_ACK[0]) got = 1'b1;
        end
        set_req(0, 1'b0, 8'h00);
        tests_run++;
        if (!got) begin failures++; $display("FAIL to_first_ack: none, required within 20 cycles"); end
        got = 1'b0;
        for (int t = 0; t < TO_CYC + 100 && !got; t++) begin
            @(negedge CLK);
            if (REQ_OUT_STB[0]) got = 1'b1;
        end
        tests_run += 3;
        if (!got) begin failures++; $display("FAIL to_result: REQ_OUT_STB never set, required after timeout"); end
        if (REQ_OUT_CHAR !== 8'h3f) begin failures++; $display("FAIL to_char: got %02h, required 3f", REQ_OUT_CHAR); end
        m = log_mismatch("5=");
        if (m != -1) begin failures++; $display("FAIL to_stream: diff at %0d, got %0d chars, required 5=", m, alu_log.size()); end
        oack0 = 1'b1;
        @(negedge CLK);
        oack0 = 1'b0;
        tests_run++;
        if (GRANT !== 2'b00) begin failures++; $display("FAIL to_release: GRANT %b, required 00", GRANT); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_hold_block();
        test_back_to_back();
        test_rst_mid();
        test_random();
        test_spacing_protocol();
`ifdef RPN_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
